io_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the single-cycle core's switch and key ports. It drives i_io_sw and i_io_key.
- Takes raw board KEY/SW levels and performs three steps:
  - 2-flop synchronisation into the 25 MHz core clock domain;
  - per-channel counter-based debouncing;
  - polarity normalisation.
- Outputs a clean active-high level plus single-cycle rise/fall pulses per channel.
- Lets firmware polling the key register see one clean transition per press.

---
 rtl/io_debounce_pkg.sv | 18 +
 rtl/io_debounce_channel.sv | 96 +++++++++
 rtl/io_debounce.sv | 52 +++++
 tb/tb_io_debounce.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_debounce_pkg.sv
// Shared types and constants for the board input debounce slice.
// Channel map: KEY[2:0] on bits [2:0], SW[9:0] on bits [12:3].
package io_debounce_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_COUNT
  } db_state_e;

  localparam int KEY_CH   = 3;
  localparam int SW_CH    = 10;
  localparam int DB_WIDTH = KEY_CH + SW_CH;

  // Push-buttons idle high on the board
  localparam logic [DB_WIDTH-1:0] DEF_ACTIVE_LOW_MASK =
    13'h0007;

endpackage

// File: rtl/io_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability FSM,
// acceptance counter and registered level/edge outputs.
module debounce_channel
  import io_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic ACTIVE_LOW      = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic          stable_d;
  logic          level_d;
  db_state_e     state;
  db_state_e     state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta <= ACTIVE_LOW;
      sync <= ACTIVE_LOW;
    end else begin
      meta <= i_raw;
      sync <= meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= ST_STABLE;
      cnt    <= '0;
      stable <= ACTIVE_LOW;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      stable <= stable_d;
    end
  end

  // Any sample equal to the accepted value drops all credit
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    stable_d = stable;
    unique case (state)
      ST_STABLE: begin
        if (sync != stable) begin
          state_d = ST_COUNT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (sync == stable) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          stable_d = sync;
          state_d  = ST_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase
  end

  assign level_d = stable ^ ACTIVE_LOW;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      o_level <= level_d;
      o_rise  <= level_d & ~o_level;
      o_fall  <= ~level_d & o_level;
    end
  end

endmodule

// File: rtl/io_debounce.sv
// Debounced KEY/SW conditioning for the core's switch/key ports.
// Optional sticky press register: IO_DEBOUNCE_EVENT_LATCH_EN.
module io_debounce
  import io_debounce_pkg::*;
#(
  parameter int WIDTH           = 13,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK =
    WIDTH'(DEF_ACTIVE_LOW_MASK)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_raw,
`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
  input  logic             i_evt_clr,
  output logic [WIDTH-1:0] o_evt_latched,
`endif
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_any_event
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[g])
    ) u_ch (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_raw[g]),
      .o_level (o_level[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g])
    );
  end

  assign o_any_event = |(o_rise | o_fall);

`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
  // Set has priority so a press coinciding with a clear survives
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_evt_latched <= '0;
    end else begin
      o_evt_latched <=
        (o_evt_latched & ~{WIDTH{i_evt_clr}}) | o_rise;
    end
  end
`endif

endmodule

// File: tb/tb_io_debounce.sv
// Scoreboard bench for io_debounce with DEBOUNCE_CYCLES = 8.
// Reference: a level flips once N consecutive synced samples differ.
module tb_io_debounce;

  localparam int W = 13;
  localparam int N = 8;
  localparam logic [W-1:0] MASK = 13'h0007;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] lvl;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any;
`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
  logic         clr;
  logic         clr_req = 1'b0;
  logic [W-1:0] latched;
`endif

  io_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N),
    .ACTIVE_LOW_MASK (MASK)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_raw         (raw),
`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
    .i_evt_clr     (clr),
    .o_evt_latched (latched),
`endif
    .o_level       (lvl),
    .o_rise        (rise),
    .o_fall        (fall),
    .o_any_event   (any)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } ev_t;

  ev_t          evq[$];
  logic [W-1:0] win[$];
  logic [W-1:0] m_r1 = MASK;
  logic [W-1:0] m_r2 = MASK;
  logic [W-1:0] m_stable = MASK;
  logic [W-1:0] m_lvl = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_lat = '0;

  task automatic chk(input string nm,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm,
                       input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Predicts what the DUT does at the coming clock edge
  task automatic model(input logic [W-1:0] v,
                       input logic r, input logic c);
    logic [W-1:0] fin, nl, nr, nf;
    bit diff;
    if (r) begin
      m_r1 = MASK;
      m_r2 = MASK;
      m_stable = MASK;
      m_lvl = '0;
      m_rise = '0;
      m_lat = '0;
      win.delete();
    end else begin
      fin = m_r2;
      m_r2 = m_r1;
      m_r1 = v;
      nl = m_stable ^ MASK;
      nr = nl & ~m_lvl;
      nf = ~nl & m_lvl;
      m_lat = (m_lat & ~{W{c}}) | m_rise;
      m_rise = nr;
      m_lvl = nl;
      if ((nr | nf) != '0)
        evq.push_back('{edge_cnt + 1, nr, nf});
      win.push_back(fin);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        for (int b = 0; b < W; b++) begin
          diff = 1'b1;
          foreach (win[k])
            if (win[k][b] == m_stable[b]) diff = 1'b0;
          if (diff) m_stable[b] = ~m_stable[b];
        end
      end
    end
  endtask

  task automatic step(input logic [W-1:0] v,
                      input logic r);
    logic c;
    c = 1'b0;
    @(negedge clk);
    raw = v;
    rst = r;
`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
    clr = clr_req;
    c = clr_req;
`endif
    model(v, r, c);
  endtask

  task automatic hold(input logic [W-1:0] v,
                      input int n);
    repeat (n) step(v, 1'b0);
  endtask

  always begin
    ev_t e;
    @(posedge clk);
    #1;
    chk("level", lvl, m_lvl);
    chk("rise_and_fall", rise & fall, '0);
    chk("any_event", W'(any), W'(|(rise | fall)));
`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
    chk("latched", latched, m_lat);
`endif
    if (any) begin
      if (evq.size() == 0) begin
        chk("unexpected_event", rise | fall, '0);
      end else begin
        e = evq.pop_front();
        chk_i("event_cycle", edge_cnt, e.cyc);
        chk("event_rise", rise, e.r);
        chk("event_fall", fall, e.f);
      end
    end else if (evq.size() != 0 && evq[0].cyc <= edge_cnt) begin
      e = evq.pop_front();
      chk("missed_event", rise | fall, e.r | e.f);
    end
  end

  initial begin
    logic [W-1:0] cur, nxt, v;
    int rate;
    raw = MASK;
    rst = 1'b1;
`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
    clr = 1'b0;
`endif
    repeat (3) step(MASK, 1'b1);
    hold(MASK, 50);
    chk("reset_level", lvl, '0);
    chk("reset_pulses", rise | fall, '0);

    cur = MASK & ~13'h0001;
    hold(cur, 11);
    chk("key0_before_latency", lvl, '0);
    step(cur, 1'b0);
    chk("key0_level", lvl, 13'h0001);
    chk("key0_rise", rise, 13'h0001);
    step(cur, 1'b0);
    chk("key0_rise_one_cycle", rise, '0);

    repeat (4) begin
      hold(cur | 13'h0008, 5);
      hold(cur, 5);
    end
    hold(cur, 15);
    chk("sw0_glitch_level", lvl, 13'h0001);

    hold(cur | 13'h1000, 7);
    step(cur, 1'b0);
    hold(cur | 13'h1000, 11);
    chk("sw9_no_early_accept", lvl, 13'h0001);
    step(cur | 13'h1000, 1'b0);
    chk("sw9_accept", lvl, 13'h1001);
    cur = cur | 13'h1000;
    hold(cur, 5);

    nxt = (cur & ~13'h0002) | 13'h0100;
    hold(nxt, 12);
    chk("dual_rise", rise, 13'h0102);
    chk("dual_any", W'(any), 13'h0001);
    step(nxt, 1'b0);
    chk("dual_any_once", W'(any), '0);
    hold(cur, 12);
    chk("dual_fall", fall, 13'h0102);

    hold(MASK, 15);
    chk("released", lvl, '0);
    nxt = MASK & ~13'h0004;
    hold(nxt, 8);
    repeat (3) step(nxt, 1'b1);
    chk("mid_reset_level", lvl, '0);
    chk("mid_reset_pulse", rise | fall, '0);
    hold(nxt, 11);
    chk("key2_after_reset_early", lvl, '0);
    step(nxt, 1'b0);
    chk("key2_after_reset_rise", rise, 13'h0004);
    hold(MASK, 15);

`ifdef IO_DEBOUNCE_EVENT_LATCH_EN
    clr_req = 1'b1;
    step(MASK, 1'b0);
    clr_req = 1'b0;
    step(MASK, 1'b0);
    chk("latch_cleared", latched, '0);
    hold(MASK & ~13'h0001, 14);
    hold(MASK, 14);
    chk("latch_sticky", latched, 13'h0001);
    clr_req = 1'b1;
    step(MASK, 1'b0);
    clr_req = 1'b0;
    step(MASK, 1'b0);
    chk("latch_lone_clear", latched, '0);
    hold(MASK & ~13'h0001, 12);
    clr_req = 1'b1;
    step(MASK & ~13'h0001, 1'b0);
    clr_req = 1'b0;
    step(MASK & ~13'h0001, 1'b0);
    chk("latch_set_wins", latched, 13'h0001);
    hold(MASK, 15);
`endif

    cur = MASK;
    rate = 16;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0)
        rate = ($urandom_range(1) == 0) ? 4 : 40;
      v = cur;
      for (int b = 0; b < W; b++)
        if ($urandom_range(rate - 1) == 0) v[b] = ~v[b];
      cur = v;
      step(cur, $urandom_range(1499) == 0);
    end
    hold(cur, 20);
    @(posedge clk);
    #2;
    chk_i("queue_drained", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
